// File: rtl/imem_pkg_da.sv
// Shared types and constants for the instruction-memory responder.
// Holds the FSM state encoding, the NOP fill word and the wait-state limit.
package imem_pkg_da;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } imem_state_e;

    localparam logic [31:0] NOP_WORD         = 32'h0;
    localparam int          IMEM_MAX_LATENCY = 7;

endpackage

// File: rtl/imem_array_da.sv
// Program image: word array with a registered read port, filled by the environment.
// Read data appears one cycle after rd_en; the read register holds otherwise.
// No backpressure: rd_en is sampled every cycle and the captured word stays put until the next fetch.
module imem_array_da
    import imem_pkg_da::*;
#(
    parameter int    DEPTH_WORDS = 256,
    parameter string INIT_FILE   = "imem.hex",
    localparam int   AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rd_en,
    input  logic          rd_clr,
    input  logic [AW-1:0] rd_idx,
    output logic [31:0]   rd_data
);

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rd_data_q;
    logic [31:0] rd_data_d;

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) rd_data_d = rd_clr ? NOP_WORD : mem[rd_idx];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rd_data_q <= NOP_WORD;
        else        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/imem_responder_da.sv
// Fetch responder: one outstanding request, response 1+LATENCY cycles after accept; flush drops it.
// Response held until resp_ready; define IMEM_CHECK_EN to flag misaligned/out-of-range fetches.
module imem_responder_da
    import imem_pkg_da::*;
#(
    parameter int    DEPTH_WORDS = 256,
    parameter int    LATENCY     = 2,
    parameter string INIT_FILE   = "imem.hex"
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_flush,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic [31:0] resp_addr,
    output logic        resp_err,
    output logic        busy
);

    localparam int         AW     = $clog2(DEPTH_WORDS);
    localparam logic [2:0] LAT_M1 = (LATENCY == 0) ? 3'd0 : 3'(LATENCY - 1);

    if (LATENCY < 0 || LATENCY > IMEM_MAX_LATENCY) begin : g_bad_latency
        $error("imem_responder_da: LATENCY must be within 0..7");
    end

    imem_state_e state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        err_q, err_d;
    logic        accept;
    logic        req_err;
    logic        req_oor;
    logic        unused_addr_bits;

    assign req_ready = !req_flush && (state_q == IDLE || (state_q == RESP && resp_ready));
    assign accept    = req_valid && req_ready;

`ifdef IMEM_CHECK_EN
    assign req_oor = (req_addr[31:AW+2] != '0);
    assign req_err = req_oor || (req_addr[1:0] != 2'b00);
`else
    assign req_oor = 1'b0;
    assign req_err = 1'b0;
`endif
    assign unused_addr_bits = ^{req_addr[31:AW+2], req_addr[1:0]};

    // The word is captured at accept; WAIT only burns cycles before exposing it.
    imem_array_da #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .INIT_FILE   (INIT_FILE)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .rd_en   (accept),
        .rd_clr  (req_oor),
        .rd_idx  (req_addr[AW+1:2]),
        .rd_data (resp_data)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        err_d   = err_q;
        case (state_q)
            IDLE: state_d = IDLE;
            WAIT: begin
                if (req_flush)         state_d = IDLE;
                else if (cnt_q == 3'd0) state_d = RESP;
                else                   cnt_d   = cnt_q - 3'd1;
            end
            RESP: if (req_flush || resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // accept already excludes flush, so it safely overrides the above.
        if (accept) begin
            state_d = (LATENCY == 0) ? RESP : WAIT;
            cnt_d   = LAT_M1;
            addr_d  = req_addr;
            err_d   = req_err;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            addr_q  <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
        end
    end

    assign resp_valid = (state_q == RESP);
    assign busy       = (state_q != IDLE);
    assign resp_addr  = addr_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_imem_responder_da.sv
// Bench for imem_responder_da: three instances (LATENCY 0, 2, 7) checked against a transaction-level model.
module tb_imem_responder_da;

    localparam int DEPTH = 256;
    localparam int NL    = 3;

    logic        clk;
    logic        reset;
    logic        req_valid  [NL];
    logic        req_ready  [NL];
    logic [31:0] req_addr   [NL];
    logic        req_flush  [NL];
    logic        resp_valid [NL];
    logic        resp_ready [NL];
    logic [31:0] resp_data  [NL];
    logic [31:0] resp_addr  [NL];
    logic        resp_err   [NL];
    logic        busy       [NL];

    for (genvar g = 0; g < NL; g++) begin : g_dut
        imem_responder_da #(
            .DEPTH_WORDS (DEPTH),
            .LATENCY     (g == 0 ? 0 : (g == 1 ? 2 : 7)),
            .INIT_FILE   ("")
        ) u_dut (
            .clk        (clk),
            .reset      (reset),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_addr   (req_addr[g]),
            .req_flush  (req_flush[g]),
            .resp_valid (resp_valid[g]),
            .resp_ready (resp_ready[g]),
            .resp_data  (resp_data[g]),
            .resp_addr  (resp_addr[g]),
            .resp_err   (resp_err[g]),
            .busy       (busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [31:0] ref_mem [DEPTH];
    bit          m_busy  [NL];
    int          m_t     [NL];
    logic [31:0] m_addr  [NL];

    function automatic int lat(int k);
        return (k == 0) ? 0 : ((k == 1) ? 2 : 7);
    endfunction

    function automatic logic exp_err(logic [31:0] a);
`ifdef IMEM_CHECK_EN
        return (a[1:0] != 2'b00) || (a[31:10] != 22'h0);
`else
        return (a == 32'hFFFF_FFFF) && (a != 32'hFFFF_FFFF);
`endif
    endfunction

    function automatic logic [31:0] exp_data(logic [31:0] a);
        logic [7:0] idx;
        idx = a[9:2];
`ifdef IMEM_CHECK_EN
        if (a[31:10] != 22'h0) return 32'h0;
`endif
        return ref_mem[idx];
    endfunction

    task automatic chk(string tag, int k, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s lane%0d observed=%08h expected=%08h", tag, k, obs, exp);
        end
    endtask

    task automatic set_all(logic v, logic [31:0] a, logic rr, logic fl);
        for (int k = 0; k < NL; k++) begin
            req_valid[k]  = v;
            req_addr[k]   = a;
            resp_ready[k] = rr;
            req_flush[k]  = fl;
        end
    endtask

    // One clock: check outputs against the model, then advance the model past the edge.
    task automatic step();
        bit          acc [NL];
        bit          hs  [NL];
        logic [31:0] a   [NL];
        #1;
        for (int k = 0; k < NL; k++) begin
            bit vis;
            bit rdy;
            vis = m_busy[k] && (cyc >= m_t[k] + lat(k));
            rdy = !req_flush[k] && (!m_busy[k] || (vis && resp_ready[k]));
            chk("req_ready", k, 32'(req_ready[k]), 32'(rdy));
            chk("busy", k, 32'(busy[k]), 32'(m_busy[k]));
            chk("resp_valid", k, 32'(resp_valid[k]), 32'(vis));
            if (vis) begin
                chk("resp_data", k, resp_data[k], exp_data(m_addr[k]));
                chk("resp_addr", k, resp_addr[k], m_addr[k]);
                chk("resp_err", k, 32'(resp_err[k]), 32'(exp_err(m_addr[k])));
            end
            acc[k] = req_valid[k] && rdy;
            hs[k]  = vis && resp_ready[k] && !req_flush[k];
            a[k]   = req_addr[k];
        end
        @(posedge clk);
        cyc++;
        for (int k = 0; k < NL; k++) begin
            if ((req_flush[k] && m_busy[k]) || hs[k]) m_busy[k] = 1'b0;
            if (acc[k]) begin
                m_busy[k] = 1'b1;
                m_t[k]    = cyc;
                m_addr[k] = a[k];
            end
        end
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(string tag);
        for (int k = 0; k < NL; k++) begin
            chk({tag, "_valid"}, k, 32'(resp_valid[k]), 32'h0);
            chk({tag, "_busy"}, k, 32'(busy[k]), 32'h0);
            chk({tag, "_data"}, k, resp_data[k], 32'h0);
            chk({tag, "_addr"}, k, resp_addr[k], 32'h0);
            chk({tag, "_err"}, k, 32'(resp_err[k]), 32'h0);
        end
    endtask

    task automatic idle_steps(int n);
        set_all(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < n; i++) step();
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 7);
        if (r < 6)  return {22'h0, 8'($urandom_range(0, DEPTH - 1)), 2'b00};
        if (r == 6) return {22'h0, 8'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(1, 3))};
        return $urandom;
    endfunction

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = $urandom;
        for (int i = 0; i < DEPTH; i++) begin
            g_dut[0].u_dut.u_array.mem[i] = ref_mem[i];
            g_dut[1].u_dut.u_array.mem[i] = ref_mem[i];
            g_dut[2].u_dut.u_array.mem[i] = ref_mem[i];
        end
        for (int k = 0; k < NL; k++) begin
            m_busy[k] = 1'b0;
            m_t[k]    = 0;
            m_addr[k] = 32'h0;
        end

        reset = 1'b0;
        set_all(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b1;
        @(negedge clk);

        // Single fetch of 0x00 with resp_ready high.
        set_all(1'b1, 32'h0, 1'b1, 1'b0);
        step();
        idle_steps(10);

        // Back-to-back stream 0x00, 0x04, 0x08.
        for (int i = 0; i < 3; i++) begin
            set_all(1'b1, 32'(i * 4), 1'b1, 1'b0);
            step();
        end
        idle_steps(10);

        // Backpressure: hold the response for several cycles.
        set_all(1'b1, 32'h20, 1'b0, 1'b0);
        step();
        set_all(1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) step();
        idle_steps(3);

        // Flush one cycle after accepting 0x10 while 0x40 is offered.
        set_all(1'b1, 32'h10, 1'b1, 1'b0);
        step();
        set_all(1'b1, 32'h40, 1'b1, 1'b1);
        step();
        set_all(1'b1, 32'h40, 1'b1, 1'b0);
        step();
        idle_steps(10);

        // Flush in IDLE only masks req_ready.
        set_all(1'b1, 32'h8, 1'b1, 1'b1);
        step();
        idle_steps(2);

        // Out-of-range and misaligned fetches.
        set_all(1'b1, 32'h400, 1'b1, 1'b0);
        step();
        idle_steps(10);
        set_all(1'b1, 32'h06, 1'b1, 1'b0);
        step();
        idle_steps(10);

        // Asynchronous reset while lanes are mid-flight.
        set_all(1'b1, 32'h1C, 1'b0, 1'b0);
        step();
        set_all(1'b0, 32'h0, 1'b0, 1'b0);
        step();
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        for (int k = 0; k < NL; k++) m_busy[k] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        set_all(1'b1, 32'h04, 1'b1, 1'b0);
        step();
        idle_steps(10);

        // Randomized traffic, each lane independent.
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < NL; k++) begin
                req_valid[k]  = ($urandom_range(0, 3) != 0);
                req_addr[k]   = rand_addr();
                resp_ready[k] = ($urandom_range(0, 3) != 0);
                req_flush[k]  = ($urandom_range(0, 15) == 0);
            end
            step();
        end
        idle_steps(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
